// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Loader states, byte-lane geometry, count-width helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        START,
        DONE,
        ERROR
    } state_t;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_IW = $clog2(LANES);

    // words_loaded must hold the full depth, not just depth-1
    function automatic int wl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
// Ports: clk, rst_n, clear, accept, last, byte_data -> word_full, word_data.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      accept,
    input  logic                      last,
    input  logic [LANE_W-1:0]         byte_data,
    output logic                      word_full,
    output logic [LANE_W*LANES-1:0]   word_data
);

    logic [LANE_IW-1:0]       lane_q;
    logic [LANE_W*LANES-1:0]  word_q;

    // word_data already includes the byte being accepted this cycle
    always_comb begin
        word_data = word_q;
        word_data[lane_q*LANE_W +: LANE_W] = byte_data;
    end

    assign word_full = accept &
        ((lane_q == LANE_IW'(LANES-1)) | last);

    // unfilled lanes stay zero because the word restarts cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (clear || word_full) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (accept) begin
            word_q <= word_data;
            lane_q <= lane_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> imem words, then CPU start pulse.
// Ports: byte handshake in, imem write port + cpu_start/status out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          START_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        start_n,
    input  logic        load_en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [wl_width(IMEM_DEPTH_WORDS)-1:0] words_loaded
);

    localparam int WLW = wl_width(IMEM_DEPTH_WORDS);
    localparam int CW  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    state_t          state_q, state_d;
    logic            we_d, start_d, done_d, err_d;
    logic            last_q, last_d;
    logic [31:0]     addr_d, wdata_d;
    logic [WLW-1:0]  wl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept, clear, full;
    logic [31:0]     word;

    assign byte_ready = (state_q == RECV);
    assign busy       = (state_q == RECV) || (state_q == WRITE) ||
                        (state_q == START);
    assign accept     = byte_valid & byte_ready;
    assign clear      = (state_q == IDLE) & load_en;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (start_n),
        .clear     (clear),
        .accept    (accept),
        .last      (byte_last),
        .byte_data (byte_data),
        .word_full (full),
        .word_data (word)
    );

    // outputs are registered, so the write strobe is loaded on
    // the edge that accepts the completing byte
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        start_d = 1'b0;
        addr_d  = imem_addr;
        wdata_d = imem_wdata;
        done_d  = done;
        err_d   = err;
        wl_d    = words_loaded;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = RECV;
                    wl_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RECV: begin
                if (full) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + (32'(words_loaded) << 2);
                    wdata_d = word;
                    last_d  = byte_last;
                end
            end
            WRITE: begin
                wl_d = words_loaded + 1'b1;
                if (last_q) begin
                    state_d = START;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end else if (words_loaded ==
                             WLW'(IMEM_DEPTH_WORDS-1)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            START: begin
                if (cnt_q == CW'(START_CYCLES-1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE:    if (!load_en) state_d = IDLE;
            ERROR:   if (!load_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state_q      <= IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            cpu_start    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_we      <= we_d;
            imem_addr    <= addr_d;
            imem_wdata   <= wdata_d;
            cpu_start    <= start_d;
            done         <= done_d;
            err          <= err_d;
            words_loaded <= wl_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (depth 4, base 0).
// Random byte streams checked against a word-image model.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int WLW   = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           start_n;
    logic           load_en;
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           byte_last;
    logic           byte_ready;
    logic           imem_we;
    logic [31:0]    imem_addr;
    logic [31:0]    imem_wdata;
    logic           cpu_start;
    logic           busy;
    logic           done;
    logic           err;
    logic [WLW-1:0] words_loaded;

    imem_loader #(
        .IMEM_DEPTH_WORDS (DEPTH),
        .BASE_ADDR        (32'h0000_0000),
        .START_CYCLES     (1)
    ) dut (
        .clk          (clk),
        .start_n      (start_n),
        .load_en      (load_en),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_start    (cpu_start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  prog [0:63];
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    int          starts = 0;
    int          acc    = 0;
    int          viol   = 0;
    int          q0, s0, a0, v0;

    always @(negedge clk) begin
        if (start_n) begin
            if (imem_we) begin
                wa.push_back(imem_addr);
                wd.push_back(imem_wdata);
            end
            if (cpu_start) starts++;
            if (byte_ready && (imem_we || cpu_start)) viol++;
        end
    end

    always @(posedge clk) begin
        if (start_n && byte_valid && byte_ready) acc++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w, input int n);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (4*w + b < n) r[8*b +: 8] = prog[4*w + b];
        return r;
    endfunction

    task automatic begin_test();
        q0 = wa.size();
        s0 = starts;
        a0 = acc;
        v0 = viol;
    endtask

    // drive n bytes from prog[]; stops early if err rises
    task automatic send(input int n, input bit with_last,
                        input int gap);
        int  i;
        int  cyc;
        bit  hs;
        bit  pend;
        bit  tmo;
        bit  stop;
        i = 0; pend = 0; tmo = 0; stop = 0;
        load_en = 1'b1;
        while (i < n && !tmo && !stop) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    if (pend) begin
                        check("we_lat", imem_we, 1);
                        pend = 0;
                    end
                    byte_valid = 1'b0;
                    byte_data  = 8'($urandom);
                    byte_last  = 1'($urandom);
                    @(posedge clk);
                end
            end
            cyc = 0;
            hs  = 0;
            while (!hs) begin
                @(negedge clk);
                if (pend) begin
                    check("we_lat", imem_we, 1);
                    pend = 0;
                end
                if (err) begin
                    stop = 1;
                    break;
                end
                byte_valid = 1'b1;
                byte_data  = prog[i];
                byte_last  = with_last && (i == n - 1);
                hs = byte_ready;
                @(posedge clk);
                cyc++;
                if (!hs && cyc > 40) begin
                    tmo = 1;
                    break;
                end
            end
            if (hs) begin
                pend = (i % 4 == 3) || byte_last;
                i++;
            end
        end
        @(negedge clk);
        if (pend) check("we_lat", imem_we, 1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        check("hs_tmo", 32'(tmo), 0);
    endtask

    task automatic finish_check(input string t, input int n,
                                input bit with_last);
        int nw;
        bit ok;
        int exp_w;
        nw    = (n + 3) / 4;
        ok    = with_last && (nw <= DEPTH);
        exp_w = ok ? nw : DEPTH;
        for (int c = 0; c < 100; c++) begin
            if (done || err) break;
            @(negedge clk);
        end
        check({t, "_end"}, 32'(done | err), 1);
        repeat (3) @(negedge clk);
        check({t, "_nwr"}, 32'(wa.size() - q0), 32'(exp_w));
        for (int k = 0; k < exp_w && q0 + k < wa.size(); k++) begin
            check($sformatf("%s_a%0d", t, k), wa[q0+k], 32'(4*k));
            check($sformatf("%s_d%0d", t, k), wd[q0+k],
                  exp_word(k, n));
        end
        check({t, "_done"},  32'(done), 32'(ok));
        check({t, "_err"},   32'(err), 32'(!ok));
        check({t, "_wl"},    32'(words_loaded), 32'(exp_w));
        check({t, "_start"}, 32'(starts - s0), ok ? 1 : 0);
        check({t, "_acc"},   32'(acc - a0), ok ? n : 4*DEPTH);
        check({t, "_rdy"},   32'(byte_ready), 0);
        check({t, "_viol"},  32'(viol - v0), 0);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        check({t, "_busy"},  32'(busy), 0);
        check({t, "_hold"},  32'(done), 32'(ok));
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) prog[k] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] t1 [0:7];
        int n;
        t1 = '{8'h13, 8'h05, 8'h00, 8'h00,
               8'hB3, 8'h05, 8'hB5, 8'h00};
        start_n    = 1'b0;
        load_en    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy",  32'(byte_ready), 0);
        check("rst_we",   32'(imem_we), 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wd",   imem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done | err | cpu_start), 0);
        check("rst_wl",   32'(words_loaded), 0);
        start_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) prog[k] = t1[k];
        begin_test();
        send(8, 1, 0);
        finish_check("two", 8, 1);
        check("two_w0", wd[q0], 32'h0000_0513);
        check("two_w1", wd[q0+1], 32'h00B5_05B3);

        prog[0] = 8'h6F;
        prog[1] = 8'h00;
        begin_test();
        send(2, 1, 0);
        finish_check("part", 2, 1);
        check("part_w0", wd[q0], 32'h0000_006F);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 16);
            fill_rand(n);
            begin_test();
            send(n, 1, 40);
            finish_check($sformatf("rnd%0d", r), n, 1);
        end

        fill_rand(20);
        begin_test();
        send(20, 0, 0);
        finish_check("ovf", 20, 0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(16, 24);
            fill_rand(n);
            begin_test();
            send(n, 0, 30);
            finish_check($sformatf("rovf%0d", r), n, 0);
        end

        fill_rand(16);
        begin_test();
        send(16, 1, 20);
        finish_check("fit", 16, 1);

        fill_rand(8);
        begin_test();
        send(6, 0, 0);
        #1 start_n = 1'b0;
        #1;
        check("ar_rdy",  32'(byte_ready), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_we",   32'(imem_we), 0);
        check("ar_addr", imem_addr, 0);
        check("ar_wd",   imem_wdata, 0);
        check("ar_flag", 32'(done | err | cpu_start), 0);
        check("ar_wl",   32'(words_loaded), 0);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        check("ar_nwr",  32'(wa.size() - q0), 1);
        check("ar_nst",  32'(starts - s0), 0);
        start_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_rand(7);
        begin_test();
        send(7, 1, 0);
        finish_check("post", 7, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Writes each word into instruction memory, then issues the CPU start pulse.
- Replaces the bench-driven start pulse with a hardware-sequenced load-then-run flow.

Parameters:
IMEM_DEPTH_WORDS, 256, instruction memory capacity in 32-bit words (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned
START_CYCLES, 1, number of cycles cpu_start is held high (>=1)

Ports:
clk  input  1  system clock, rising edge
start_n  input  1  asynchronous active-low reset
load_en  input  1  level request to begin a load; sampled in IDLE
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  program byte
byte_last  input  1  qualifies byte_data as the final program byte
byte_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe
imem_addr  output  32  instruction-memory byte address
imem_wdata  output  32  instruction-memory write data
cpu_start  output  1  CPU start/reset pulse
busy  output  1  high in RECV, WRITE or START
done  output  1  load completed successfully
err  output  1  overflow: program longer than IMEM_DEPTH_WORDS
words_loaded  output  $clog2(IMEM_DEPTH_WORDS)+1  count of words written

Behaviour:
- Reset (start_n low, asynchronous): state=IDLE. byte_ready, imem_we, cpu_start, busy, done and err are 0. imem_addr=BASE_ADDR. imem_wdata=0, words_loaded=0. Byte lane index=0.
- Reset mid-operation aborts immediately. A partially assembled word is discarded, and no write or start pulse is issued.
- All outputs are registered except byte_ready and busy, which are decoded from state.
- IDLE -> RECV when load_en=1 (needs load_en=0 in IDLE first after DONE/ERROR). On entry, words_loaded=0, lane index=0 and the word register is cleared.
- RECV:
  - byte_ready=1. A byte is accepted when byte_valid & byte_ready.
  - The accepted byte goes into lane index*8 +: 8, so the first byte lands in [7:0].
  - The lane index increments on each accepted byte.
  - On accepting lane 3, or any byte with byte_last=1, go to WRITE.
  - Lanes not filled when byte_last arrives are zero-padded; this is not an error.
  - load_en changes while in RECV are ignored.
- WRITE (exactly 1 cycle):
  - byte_ready=0, imem_we=1, imem_addr=BASE_ADDR + 4*words_loaded, imem_wdata=assembled word.
  - words_loaded increments at the end of the cycle and the lane index resets to 0.
  - Next state:
    - START if the word carried byte_last.
    - Otherwise ERROR if this was word IMEM_DEPTH_WORDS-1.
    - Otherwise RECV.
- Latency: imem_we is asserted in the cycle after the accepting clock edge of the 4th or last byte. Maximum rate is 1 word per 5 cycles.
- START: cpu_start=1 for exactly START_CYCLES consecutive cycles, counted by an internal counter. Then go to DONE.
- DONE: done=1, cpu_start=0. Hold until load_en=0, then go to IDLE; done stays 1 in IDLE until the next load begins.
- ERROR: err=1, no cpu_start is ever issued, byte_ready=0. Leave to IDLE on load_en=0; err clears when the next load begins.
- Boundaries:
  - A last byte that completes word IMEM_DEPTH_WORDS-1 is success, not error.
  - byte_valid while byte_ready=0 is ignored; the source must hold the byte.
  - imem_addr wrap cannot occur, because ERROR precedes it.

Decomposition:
- Shared package:
  - state enum (IDLE, RECV, WRITE, START, DONE, ERROR)
  - byte-lane width constant (8) and lanes-per-word constant (4)
  - helper for the words_loaded width
- One natural sub-module, imem_word_packer: lane index counter plus the 32-bit shift/insert register. It has clear/accept/last inputs and word_full/word_data outputs.
- FSM, address and START counter stay in imem_loader.

Test Plan:
- Two full words, bytes 13,05,00,00 then B3,05,B5,00 with last on the final byte:
  - imem_we at addr 0x0 with 0x00000513, then at 0x4 with 0x00B505B3.
  - cpu_start high for 1 cycle, done=1, words_loaded=2.
- Partial final word, bytes 6F,00 with last on the 2nd: one write of 0x0000006F at BASE_ADDR; success.
- Backpressure and gaps, with byte_valid toggled randomly:
  - Only handshaked bytes are packed.
  - No byte is accepted during WRITE or START; data matches the expected image.
- Overflow with IMEM_DEPTH_WORDS=4, 20 bytes without last:
  - 4 writes at 0x0..0xC, then err=1.
  - No cpu_start; byte_ready stays 0.
- Exact fit with IMEM_DEPTH_WORDS=4, 16 bytes, last on byte 16: 4 writes, done=1, err=0.
- Async reset mid-load: drop start_n after 6 bytes, with 1 word written:
  - All outputs zero at once; no further imem_we.
  - A fresh load afterwards starts at BASE_ADDR.
